// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  // Default byte width of every requester lane and of the transmitter port.
  localparam int unsigned DEF_DATA_W = 8;

  // Arbiter FSM: wait for requests, offer a byte, one-cycle spacing between bytes.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first active request at or after i_ptr wins.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  int unsigned w_cand;

  // Walk ptr, ptr+1, ... wrapping at NUM_REQ; the first hit is latched by o_valid.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    w_cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = 32'(i_ptr) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
        o_valid                     = 1'b1;
        o_idx                       = w_cand[IDX_W-1:0];
        o_grant[w_cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ burst sources.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  input  logic [NUM_REQ-1:0]        i_last,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_tx_valid,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_ready
);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_busy;
  logic                r_tx_valid;
  logic [DATA_W-1:0]   r_tx_data;

  logic [DATA_W-1:0]   w_data [NUM_REQ];
  logic                w_pick_valid;
  logic [NUM_REQ-1:0]  w_pick_grant;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [IDX_W-1:0]    w_ptr_next;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_data[g] = i_data[g*DATA_W +: DATA_W];
  end

  // Pointer moves one past the current owner so it ranks last in the next search.
  assign w_ptr_next = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  // Burst FSM with registered outputs; a transfer outranks a same-edge request drop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        StIdle: begin
          if (w_pick_valid) begin
            r_state    <= StSend;
            r_gnt_idx  <= w_pick_idx;
            r_grant    <= w_pick_grant;
            r_busy     <= 1'b1;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_data[w_pick_idx];
          end
        end
        StSend: begin
          if (i_tx_ready) begin
            r_ack      <= r_grant;
            r_tx_valid <= 1'b0;
            if (i_last[r_gnt_idx]) begin
              r_state <= StIdle;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_ptr   <= w_ptr_next;
            end else begin
              r_state <= StGap;
            end
          end else if (!i_req[r_gnt_idx]) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_ptr      <= w_ptr_next;
          end
        end
        StGap: begin
          if (i_req[r_gnt_idx]) begin
            r_state    <= StSend;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_data[r_gnt_idx];
          end else begin
            r_state <= StIdle;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_grant    = r_grant;
  assign o_busy     = r_busy;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART byte transmitter among `NUM_REQ` requesters. Each requester submits a burst of bytes terminated by a last flag. The arbiter grants one requester for its entire burst, forwards the bytes to the transmitter over a valid/ready handshake, and acknowledges each accepted byte. It sits between the application-side message sources and the single UART TX serializer driving `o_data`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `IDX_W`, default `$clog2(NUM_REQ)`: grant index width.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous reset, active-high (one clock domain).
- `i_req`  in  NUM_REQ  per-requester request; held high for the whole burst.
- `i_data`  in  NUM_REQ*DATA_W  packed bytes, requester k at `[k*DATA_W +: DATA_W]`.
- `i_last`  in  NUM_REQ  marks the current byte as the final byte of the burst.
- `o_ack`  out  NUM_REQ  one-cycle pulse: requester's current byte was accepted.
- `o_grant`  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- `o_busy`  out  1  a burst is in progress.
- `o_tx_valid`  out  1  byte offered to the transmitter.
- `o_tx_data`  out  DATA_W  byte to transmit.
- `i_tx_ready`  in  1  transmitter can accept a byte this cycle.

## Operation
- FSM states: IDLE, SEND, GAP.
- **IDLE**
  - If `i_req != 0`, pick the winner with a rotating search starting at pointer `ptr`: `ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1`.
  - Register the winner in `gnt_idx` and `o_grant`, set `o_busy=1`, and go to SEND.
- **SEND**
  - `o_tx_valid=1`, `o_tx_data = i_data[gnt_idx]`.
  - A transfer occurs on a clock edge where `o_tx_valid && i_tx_ready`. On a transfer, pulse `o_ack[gnt_idx]` next cycle and deassert `o_tx_valid`.
    - If `i_last[gnt_idx]` was high at the transfer: go to IDLE, clear `o_grant` and `o_busy`, set `ptr = (gnt_idx+1) mod NUM_REQ`.
    - Otherwise go to GAP.
  - If `i_req[gnt_idx]` falls while in SEND with no transfer (abort): go to IDLE, clear the grant, set `ptr = gnt_idx+1`, no ack.
- **GAP**
  - One cycle with `o_tx_valid=0`, so the requester can present its next byte after seeing the ack.
  - If `i_req[gnt_idx]` is high, return to SEND. Otherwise abort as above.
- Requester contract: hold `i_data`/`i_last` stable while `i_req` is high until `o_ack`. Non-granted requesters wait and are never acked.
- Requests arriving mid-burst are ignored until IDLE. A burst is never preempted.
- `ptr` wraps from `NUM_REQ-1` to 0. This guarantees no starvation: worst-case wait is `NUM_REQ-1` bursts.

## Timing
- All outputs are registered.
- Reset values: `o_ack=0`, `o_grant=0`, `o_busy=0`, `o_tx_valid=0`, `o_tx_data=0`, `ptr=0`, state IDLE.
- Reset asserted mid-burst drops everything immediately. No ack is issued, and the byte in flight is abandoned.
- Request latency: `i_req` sampled high in IDLE at edge t gives `o_grant`, `o_busy` and `o_tx_valid` high from cycle t+1.
- Per-byte throughput with `i_tx_ready` constantly high: one byte every 2 cycles (SEND, GAP).
- Transfer at edge h: `o_ack` is high for exactly cycle h+1, and `o_tx_valid` is low in cycle h+1.
- After the last byte at edge h: IDLE in cycle h+1, and the next grant is visible at cycle h+2 at the earliest.
- `i_tx_ready` may stay low indefinitely. SEND holds `o_tx_valid` and `o_tx_data` stable with no timeout.
- Simultaneous `i_last` and `i_req` fall on the transfer edge: the transfer counts, the ack is issued, and the burst ends normally.

## Structure
- Package `uart_arb_pkg`: FSM state enum (IDLE, SEND, GAP) and the default `DATA_W` constant.
- Sub-module `rr_pick`: combinational rotating-priority picker. Inputs `req[NUM_REQ]` and `ptr`. Outputs `valid`, one-hot `grant` and `idx`.
- The top level holds the FSM, `ptr`, `gnt_idx` and the output registers.

## Test plan
- Reset, then single requester 1 sends burst 0x55, 0xA3 (last) with `i_tx_ready=1`: grant `0010` at t+1, tx bytes 0x55 then 0xA3 two cycles apart, two `o_ack[1]` pulses, `o_grant=0` after the last byte.
- All four requesters request 1-byte bursts continuously: grant order 0,1,2,3,0, with `ptr` wrapping 3→0.
- Requester 2 is mid-burst when requester 0 asserts: no preemption; requester 0 is granted only after requester 2's last byte, at h+2.
- Hold `i_tx_ready=0` for 20 cycles in SEND: `o_tx_valid` and `o_tx_data` stay stable with no ack; ready=1 then gives a single transfer.
- Requester 3 drops `i_req` in GAP: return to IDLE, no further ack, `ptr=0`, and a pending requester 1 is granted next.
- Assert `i_rst` during SEND: all outputs return to 0 asynchronously, and the next arbitration starts from `ptr=0`.
